// File: rtl/emac_rx_nibble_packer_if.sv
// FIFO read-side and byte-stream handshake bundle for the EMAC RX nibble packer.
// master = packer side, slave = FIFO/consumer side.
interface emac_rx_nibble_packer_if;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       fifo_rd_ack;
    logic [5:0] fifo_dout;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;
    logic       out_err;

    modport master (
        input  fifo_empty, fifo_rd_ack, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_valid, out_first, out_last, out_err
    );

    modport slave (
        output fifo_empty, fifo_rd_ack, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_first, out_last, out_err
    );
endinterface

// File: rtl/emac_rx_nibble_packer.sv
// Packs MII RX nibbles popped from a FIFO into framed bytes with first/last/err tags.
// Optional saturating frame/error statistics are enabled by defining EMAC_RX_PACK_STATS_EN.
module emac_rx_nibble_packer #(
    parameter int unsigned C_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    emac_rx_nibble_packer_if.master bus,
    output logic [C_CNT_WIDTH-1:0] frame_cnt,
    output logic [C_CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       rd_pend_q;
    logic [3:0] lo_q;
    logic       first_pend_q;
    logic       err_q;
    logic [7:0] hold_q;
    logic       hold_vld_q;
    logic       hold_first_q;

    logic       ent_er;
    logic       ent_dv;
    logic [3:0] ent_nib;
    logic       accept;

    logic       store_lo;
    logic       complete;
    logic       push;
    logic       push_last;
    logic       push_err;

    assign ent_er  = bus.fifo_dout[5];
    assign ent_dv  = bus.fifo_dout[4];
    assign ent_nib = bus.fifo_dout[3:0];
    assign accept  = bus.out_valid & bus.out_ready;

    // One read in flight; never read when a push could land on an unaccepted byte.
    assign bus.fifo_rd_en = rst_n & ~bus.fifo_empty & ~rd_pend_q
                          & (~bus.out_valid | bus.out_ready);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.fifo_rd_ack) begin
            unique case (state_q)
                ST_IDLE: if (ent_dv) state_d = ST_HI;
                ST_LO:   state_d = ent_dv ? ST_HI : ST_IDLE;
                ST_HI:   state_d = ent_dv ? ST_LO : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control decode; the held byte is only released once its successor exists or the frame ends.
    always_comb begin
        store_lo  = 1'b0;
        complete  = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        push_err  = 1'b0;
        if (bus.fifo_rd_ack) begin
            unique case (state_q)
                ST_IDLE: store_lo = ent_dv;
                ST_LO: begin
                    store_lo  = ent_dv;
                    push      = ~ent_dv & hold_vld_q;
                    push_last = ~ent_dv;
                    push_err  = ~ent_dv & err_q;
                end
                ST_HI: begin
                    complete  = ent_dv;
                    push      = hold_vld_q;
                    push_last = ~ent_dv;
                    push_err  = ~ent_dv;
                end
                default: ;
            endcase
        end
    end

    // Nibble assembly, hold register and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q     <= 1'b0;
            lo_q          <= 4'h0;
            first_pend_q  <= 1'b0;
            err_q         <= 1'b0;
            hold_q        <= 8'h00;
            hold_vld_q    <= 1'b0;
            hold_first_q  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_err   <= 1'b0;
        end else begin
            if (bus.fifo_rd_en) begin
                rd_pend_q <= 1'b1;
            end else if (bus.fifo_rd_ack) begin
                rd_pend_q <= 1'b0;
            end

            if (store_lo) begin
                lo_q <= ent_nib;
            end

            // Sticky error is cleared by any DV=0 entry, which always lands in IDLE.
            if (bus.fifo_rd_ack) begin
                err_q <= ent_dv ? (err_q | ent_er) : 1'b0;
            end

            if (bus.fifo_rd_ack && state_q == ST_IDLE && ent_dv) begin
                first_pend_q <= 1'b1;
            end else if (complete) begin
                first_pend_q <= 1'b0;
            end

            if (complete) begin
                hold_q       <= {ent_nib, lo_q};
                hold_vld_q   <= 1'b1;
                hold_first_q <= first_pend_q;
            end else if (push) begin
                hold_vld_q   <= 1'b0;
            end

            if (push) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= hold_q;
                bus.out_first <= hold_first_q;
                bus.out_last  <= push_last;
                bus.out_err   <= push_err;
            end else if (accept) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef EMAC_RX_PACK_STATS_EN
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic       runt;
    logic       frame_inc;
    logic [1:0] err_inc;

    // A frame that ends while only a dangling nibble exists produces no byte at all.
    assign runt      = bus.fifo_rd_ack & ~ent_dv & (state_q == ST_HI) & ~hold_vld_q;
    assign frame_inc = accept & bus.out_last;
    assign err_inc   = 2'(accept & bus.out_last & bus.out_err) + 2'(runt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_inc && frame_cnt != CNT_MAX) begin
                frame_cnt <= frame_cnt + C_CNT_WIDTH'(1);
            end
            if (err_cnt > CNT_MAX - C_CNT_WIDTH'(err_inc)) begin
                err_cnt <= CNT_MAX;
            end else begin
                err_cnt <= err_cnt + C_CNT_WIDTH'(err_inc);
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
